score_event_arbiter: RTL

- Collects per-target scoring events from N_SRC target sources and serialises them into one award per transaction to a single shared score accumulator.
- Each source scores at most once per round. A round-robin selector chooses among pending sources, and a valid/ready handshake delivers each award downstream.
- Sits between the target/collision logic and the game-state controller. The controller drives clear at round start and enable while playing, and reads score and all_claimed for win detection.

---
 rtl/score_arb_pkg.sv | 15 +
 rtl/score_event_arbiter_rr_pick.sv | 42 ++++
 rtl/score_event_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/score_arb_pkg.sv
// Shared types and default constants for the score event arbiter.
//   arb_state_e : arbiter FSM states (idle / offering an award)
//   DefNSrc, DefScoreW, DefPoints : default parameter values
package score_arb_pkg;

  localparam int unsigned DefNSrc   = 3;
  localparam int unsigned DefScoreW = 11;
  localparam int unsigned DefPoints = 1;

  typedef enum logic [0:0] {
    StIdle,
    StOffer
  } arb_state_e;

endpackage

// File: rtl/score_event_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at or after ptr,
// wrapping modulo N_SRC.
//   req     in  N_SRC  request vector
//   ptr     in  ID_W   starting index (must be < N_SRC)
//   gnt_id  out ID_W   index of the selected request (0 when none)
//   any_req out 1      at least one request asserted
module rr_pick #(
  parameter int unsigned N_SRC = 3,
  parameter int unsigned ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  gnt_id,
  output logic             any_req
);

  // ptr and off are both below N_SRC, so one conditional subtract wraps the sum.
  function automatic logic [ID_W-1:0] wrap_idx(input int unsigned base, input int unsigned off);
    int unsigned sum;
    sum = base + off;
    if (sum >= N_SRC) begin
      sum = sum - N_SRC;
    end
    return ID_W'(sum);
  endfunction

  logic [ID_W-1:0] cand;

  always_comb begin
    gnt_id  = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      cand = wrap_idx(32'(ptr), k);
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        gnt_id  = cand;
      end
    end
  end

endmodule

// File: rtl/score_event_arbiter.sv
// Serialises per-source scoring events into one award at a time towards a shared
// score accumulator. Each source may score once per round; sources are served
// round-robin and each award is delivered with a valid/ready handshake.
//   Clk          in  1        system clock
//   Reset        in  1        asynchronous active-high reset
//   clear        in  1        synchronous round clear (overrides all other events)
//   enable       in  1        playing phase; gates latching of hits and new offers
//   hit          in  N_SRC    level-sensitive scoring request per source
//   award_ready  in  1        downstream accepts the current award
//   award_valid  out 1        award offered
//   award_id     out ID_W     source index of the offered award
//   score        out SCORE_W  saturating accumulated score for this round
//   claimed      out N_SRC    per-source already-scored flags
//   all_claimed  out 1        every source has scored
module score_event_arbiter
  import score_arb_pkg::*;
#(
  parameter int unsigned N_SRC   = DefNSrc,
  parameter int unsigned SCORE_W = DefScoreW,
  parameter int unsigned POINTS  = DefPoints,
  localparam int unsigned ID_W   = $clog2(N_SRC)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               clear,
  input  logic               enable,
  input  logic [N_SRC-1:0]   hit,
  input  logic               award_ready,
  output logic               award_valid,
  output logic [ID_W-1:0]    award_id,
  output logic [SCORE_W-1:0] score,
  output logic [N_SRC-1:0]   claimed,
  output logic               all_claimed
);

  // Extra headroom so score + POINTS can never wrap before the saturation compare.
  localparam int unsigned SumW = SCORE_W + 32;
  localparam logic [SumW-1:0] ScoreMax = SumW'({SCORE_W{1'b1}});

  arb_state_e         state_q, state_d;
  logic [N_SRC-1:0]   pending_q, pending_d;
  logic [N_SRC-1:0]   claimed_q, claimed_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    award_id_q, award_id_d;
  logic [SCORE_W-1:0] score_q, score_d;

  logic [ID_W-1:0]    pick_id;
  logic               pick_any;
  logic               accept;
  logic [N_SRC-1:0]   set_mask;
  logic [SumW-1:0]    score_sum;
  logic [SCORE_W-1:0] score_sat;

  rr_pick #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req     (pending_q),
    .ptr     (rr_ptr_q),
    .gnt_id  (pick_id),
    .any_req (pick_any)
  );

  assign accept    = (state_q == StOffer) && award_ready;
  assign score_sum = SumW'(score_q) + SumW'(POINTS);
  assign score_sat = (score_sum > ScoreMax) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    claimed_d  = claimed_q;
    rr_ptr_d   = rr_ptr_q;
    award_id_d = award_id_q;
    score_d    = score_q;
    set_mask   = hit & ~claimed_q & {N_SRC{enable}};

    if (clear) begin
      state_d    = StIdle;
      pending_d  = '0;
      claimed_d  = '0;
      rr_ptr_d   = '0;
      award_id_d = '0;
      score_d    = '0;
    end else begin
      // The accepted source becomes claimed on this edge, so its own hit must not re-latch.
      if (accept) begin
        set_mask[award_id_q] = 1'b0;
      end
      pending_d = pending_q | set_mask;

      unique case (state_q)
        StIdle: begin
          if (enable && pick_any) begin
            award_id_d = pick_id;
            state_d    = StOffer;
          end
        end
        StOffer: begin
          if (accept) begin
            pending_d[award_id_q] = 1'b0;
            claimed_d[award_id_q] = 1'b1;
            score_d               = score_sat;
            rr_ptr_d              = (award_id_q == ID_W'(N_SRC - 1)) ? '0
                                                                      : award_id_q + ID_W'(1);
            state_d               = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      claimed_q  <= '0;
      rr_ptr_q   <= '0;
      award_id_q <= '0;
      score_q    <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      claimed_q  <= claimed_d;
      rr_ptr_q   <= rr_ptr_d;
      award_id_q <= award_id_d;
      score_q    <= score_d;
    end
  end

  assign award_valid = (state_q == StOffer);
  assign award_id    = award_id_q;
  assign score       = score_q;
  assign claimed     = claimed_q;
  assign all_claimed = &claimed_q;

endmodule
